// File: rtl/vga_bar_decoder.sv
// Receive-side VGA monitor: recovers pixel position from sync edges, tracks timing lock, decodes 16 bar heights.
// Heights latch one cycle after the vsync-qualified hsync edge; bar_height has 1-cycle read latency; no backpressure.
module vga_bar_decoder #(
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          H_DISPLAY   = 640,
    parameter int          H_TOTAL     = 800,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          V_DISPLAY   = 480,
    parameter int          V_TOTAL     = 525,
    parameter int          BAR_WIDTH   = 40,
    parameter logic [11:0] BAR_COLOUR  = 12'hC00,
    parameter int          LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    input  logic [3:0] bar_sel,
    output logic [9:0] bar_height,
    output logic       frame_valid,
    output logic       locked,
    output logic [7:0] error_count
);
    localparam logic [9:0] X0  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] X1  = 10'(H_SYNC + H_BP + H_DISPLAY);
    localparam logic [9:0] Y0  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] Y1  = 10'(V_SYNC + V_BP + V_DISPLAY);
    localparam logic [9:0] HT  = 10'(H_TOTAL);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] VD  = 10'(V_DISPLAY);
    localparam logic [9:0] BW1 = 10'(BAR_WIDTH - 1);
    localparam logic [3:0] LF  = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    logic        hs_q, hs_d_q, vs_q, vs_line_q;
    logic [11:0] rgb_q;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [3:0]  col_q, col_d;
    logic [9:0]  intra_q, intra_d;
    logic        line_armed_q, frame_armed_q;
    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic [7:0]  err_q, err_d;
    logic [8:0]  err_sum;
    logic        frame_valid_q;
    logic [9:0]  bar_height_q;
    logic [9:0]  min_row_q [16];
    logic [9:0]  height_q  [16];

    logic       hs_fall, frame_end, line_viol, frame_viol, latch, active, lit;
    logic [9:0] y_pos;

    // h_cnt_d is the horizontal position of the sample currently held in rgb_q
    always_comb begin
        hs_fall   = hs_d_q & ~hs_q;
        frame_end = hs_fall & ~vs_q & vs_line_q;

        h_cnt_d = hs_fall ? 10'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
        if (frame_end)
            v_cnt_d = 10'd0;
        else if (hs_fall && v_cnt_q != CNT_MAX)
            v_cnt_d = v_cnt_q + 10'd1;
        else
            v_cnt_d = v_cnt_q;

        // A saturated counter reports once on arrival, not again at the next edge
        line_viol  = line_armed_q &
                     ((hs_fall & (h_cnt_q != CNT_MAX) & (h_cnt_q + 10'd1 != HT)) |
                      (~hs_fall & (h_cnt_q == CNT_MAX - 10'd1)));
        frame_viol = frame_armed_q &
                     ((frame_end & (v_cnt_q != CNT_MAX) & (v_cnt_q + 10'd1 != VT)) |
                      (hs_fall & ~frame_end & (v_cnt_q == CNT_MAX - 10'd1)));

        if (h_cnt_d == X0) begin
            col_d   = 4'd0;
            intra_d = 10'd0;
        end else if (intra_q == BW1) begin
            col_d   = col_q + 4'd1;
            intra_d = 10'd0;
        end else begin
            col_d   = col_q;
            intra_d = intra_q + 10'd1;
        end

        y_pos  = v_cnt_q - Y0;
        active = (h_cnt_d >= X0) && (h_cnt_d < X1) && (v_cnt_q >= Y0) && (v_cnt_q < Y1);
        lit    = active && (rgb_q == BAR_COLOUR);

        err_sum = {1'b0, err_q} + {8'd0, line_viol} + {8'd0, frame_viol};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        latch   = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (frame_end) begin
                    state_d = ACQUIRE;
                    good_d  = 4'd0;
                end
            end
            ACQUIRE: begin
                if (line_viol || frame_viol) begin
                    state_d = UNLOCKED;
                end else if (frame_end) begin
                    if (good_q + 4'd1 == LF) begin
                        state_d = LOCKED;
                        latch   = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (line_viol || frame_viol)
                    state_d = UNLOCKED;
                else if (frame_end)
                    latch = 1'b1;
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q          <= 1'b1;
            hs_d_q        <= 1'b1;
            vs_q          <= 1'b1;
            vs_line_q     <= 1'b1;
            rgb_q         <= 12'd0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            col_q         <= 4'd0;
            intra_q       <= 10'd0;
            line_armed_q  <= 1'b0;
            frame_armed_q <= 1'b0;
            state_q       <= UNLOCKED;
            good_q        <= 4'd0;
            err_q         <= 8'd0;
            frame_valid_q <= 1'b0;
            bar_height_q  <= 10'd0;
            for (int k = 0; k < 16; k++) begin
                min_row_q[k] <= VD;
                height_q[k]  <= 10'd0;
            end
        end else begin
            hs_q          <= hsync_in;
            hs_d_q        <= hs_q;
            vs_q          <= vsync_in;
            rgb_q         <= {r_in, g_in, b_in};
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            col_q         <= col_d;
            intra_q       <= intra_d;
            state_q       <= state_d;
            good_q        <= good_d;
            err_q         <= err_d;
            frame_valid_q <= latch;
            bar_height_q  <= height_q[bar_sel];
            if (hs_fall) begin
                vs_line_q    <= vs_q;
                line_armed_q <= 1'b1;
            end
            if (frame_end)
                frame_armed_q <= 1'b1;
            if (frame_end) begin
                for (int k = 0; k < 16; k++)
                    min_row_q[k] <= VD;
            end else if (lit && (y_pos < min_row_q[col_d])) begin
                min_row_q[col_d] <= y_pos;
            end
            if (latch) begin
                for (int k = 0; k < 16; k++)
                    height_q[k] <= VD - min_row_q[k];
            end
        end
    end

    assign bar_height  = bar_height_q;
    assign frame_valid = frame_valid_q;
    assign locked      = (state_q == LOCKED);
    assign error_count = err_q;
endmodule

// File: tb/tb_vga_bar_decoder.sv
// Bench for vga_bar_decoder on scaled-down timing; frame_valid events are scoreboarded against pushed height sets.
module tb_vga_bar_decoder;
    localparam int HS  = 4;
    localparam int HBP = 4;
    localparam int HD  = 64;
    localparam int HT  = 76;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int VD  = 32;
    localparam int VT  = 38;
    localparam int BW  = 4;

    typedef logic [15:0][9:0] hset_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in;
    logic [3:0] r_in, g_in, b_in, bar_sel;
    logic [9:0] bar_height;
    logic       frame_valid, locked;
    logic [7:0] error_count;

    int    checks = 0;
    int    failures = 0;
    hset_t exp_q[$];
    hset_t pat, last_pat, prev_set, cur_set;

    vga_bar_decoder #(
        .H_SYNC(HS), .H_BP(HBP), .H_DISPLAY(HD), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VBP), .V_DISPLAY(VD), .V_TOTAL(VT),
        .BAR_WIDTH(BW), .BAR_COLOUR(12'hC00), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .bar_sel(bar_sel),
        .bar_height(bar_height), .frame_valid(frame_valid),
        .locked(locked), .error_count(error_count)
    );

    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_pix(input logic hs, input logic vs, input logic [11:0] rgb);
        hsync_in = hs;
        vsync_in = vs;
        {r_in, g_in, b_in} = rgb;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pix_at(input int p, input int l);
        int x, y, c;
        x = p - (HS + HBP);
        y = l - (VS + VBP);
        if (x < 0 || x >= HD || y < 0 || y >= VD) return 12'h000;
        c = x / BW;
        if (y >= VD - int'(pat[c])) return 12'hC00;
        if (x % BW == 0) return 12'hFFF;
        return 12'h000;
    endfunction

    // The frame end that starts this frame latches the previous frame's rendering
    task automatic send_frame(input int nlines, input int short_line, input int rst_line, input bit exp_fv);
        if (exp_fv) exp_q.push_back(last_pat);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < ((l == short_line) ? HT - 1 : HT); p++) begin
                if (l == rst_line && p == 40) begin
                    check_val("locked_pre_rst", locked, 1);
                    reset = 1'b1;
                end
                drive_pix(p >= HS, l >= VS, pix_at(p, l));
                if (reset) begin
                    reset = 1'b0;
                    prev_set = '0;
                    check_val("rst_fv", frame_valid, 0);
                    check_val("rst_locked", locked, 0);
                    check_val("rst_err", error_count, 0);
                    check_val("rst_height", bar_height, 0);
                end
            end
        end
        last_pat = pat;
    endtask

    // Monitor: on each frame_valid, pop the expected set and sweep all 16 bars
    initial begin
        bar_sel = 4'd0;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("fv_unexpected", frame_valid, 0);
                end else begin
                    cur_set = exp_q.pop_front();
                    check_val("rd_old_set", bar_height, prev_set[bar_sel]);
                    @(negedge clk);
                    check_val("rd_new_set", bar_height, cur_set[bar_sel]);
                    for (int k = 0; k < 16; k++) begin
                        bar_sel = 4'(k);
                        @(negedge clk);
                        check_val($sformatf("bar%0d", k), bar_height, cur_set[k]);
                    end
                    prev_set = cur_set;
                    bar_sel = 4'd5;
                end
            end
        end
    end

    initial begin
        pat = '0;
        last_pat = '0;
        prev_set = '0;
        reset = 1'b1;
        repeat (3) drive_pix(1'b1, 1'b1, 12'h000);
        check_val("reset_fv", frame_valid, 0);
        check_val("reset_locked", locked, 0);
        check_val("reset_err", error_count, 0);
        check_val("reset_height", bar_height, 0);
        reset = 1'b0;

        // Black frames from reset: lock on the third frame end
        send_frame(VT, -1, -1, 1'b0);
        send_frame(VT, -1, -1, 1'b0);
        check_val("locked_before_3rd", locked, 0);
        send_frame(VT, -1, -1, 1'b1);
        check_val("locked_after_3rd", locked, 1);
        check_val("err_clean", error_count, 0);

        // Bars of height 2k with white column markers
        for (int k = 0; k < 16; k++) pat[k] = 10'(2 * k);
        send_frame(VT, -1, -1, 1'b1);
        send_frame(VT, 10, -1, 1'b1);
        check_val("short_line_err", error_count, 1);
        check_val("short_line_locked", locked, 0);
        send_frame(VT, -1, -1, 1'b0);
        send_frame(VT, -1, -1, 1'b0);
        check_val("relock_pending", locked, 0);
        send_frame(VT - 1, -1, -1, 1'b1);
        check_val("relocked", locked, 1);

        // Short frame: violation, heights hold
        send_frame(VT, -1, -1, 1'b0);
        check_val("short_frame_err", error_count, 2);
        check_val("short_frame_locked", locked, 0);
        check_val("hold_bar5", bar_height, 10);

        // Lost hsync reports once, then saturate the counter
        repeat (2000) drive_pix(1'b1, 1'b1, 12'h000);
        check_val("hsync_lost_err", error_count, 3);
        check_val("hsync_lost_locked", locked, 0);
        for (int i = 0; i < 301; i++)
            for (int p = 0; p < 10; p++) drive_pix(p >= 2, 1'b1, 12'h000);
        check_val("err_saturated", error_count, 255);

        // Relock, then reset mid-frame while locked
        send_frame(VT, -1, -1, 1'b0);
        send_frame(VT, -1, -1, 1'b0);
        send_frame(VT, -1, 20, 1'b1);
        check_val("post_rst_locked1", locked, 0);
        send_frame(VT, -1, -1, 1'b0);
        send_frame(VT, -1, -1, 1'b0);
        check_val("post_rst_locked2", locked, 0);
        send_frame(VT, -1, -1, 1'b1);
        check_val("post_rst_relocked", locked, 1);
        check_val("post_rst_err", error_count, 0);
        check_val("pending_fv", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_bar_decoder.md
Name: vga_bar_decoder

Overview:
- Receive-side monitor for the 640x480 VGA bar-graph output.
- Samples hsync/vsync/RGB on the 25 MHz pixel clock and recovers pixel position from the sync edges.
- Checks line and frame timing and maintains a lock state.
- Decodes the 16 displayed bar heights back into numbers, so on-chip self-test can compare rendered bars against the FFT bins that were sent.

Parameters:
H_SYNC, 96, hsync low width in pixel clocks
H_BP, 48, horizontal back porch
H_DISPLAY, 640, active pixels per line
H_TOTAL, 800, pixel clocks per line
V_SYNC, 2, vsync low width in lines
V_BP, 33, vertical back porch in lines
V_DISPLAY, 480, active lines
V_TOTAL, 525, lines per frame
BAR_WIDTH, 40, pixels per bar column (16 columns)
BAR_COLOUR, 12'hC00, {r,g,b} value that marks a lit bar pixel
LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
clk  in  1  pixel clock, 25 MHz
reset  in  1  synchronous, active-high
hsync_in  in  1  horizontal sync, active low
vsync_in  in  1  vertical sync, active low
r_in  in  4  red
g_in  in  4  green
b_in  in  4  blue
bar_sel  in  4  bar index to read (0..15)
bar_height  out  10  latched height of bar bar_sel, 0..480; 1-cycle read latency
frame_valid  out  1  1-cycle pulse when a new set of heights has been latched
locked  out  1  high while in LOCKED
error_count  out  8  saturating count of timing violations

Behaviour:
- Reset values:
  - All outputs 0.
  - Latched heights 0; working minima set to V_DISPLAY.
  - FSM in UNLOCKED; all counters 0; previous-sync registers set to 1.
- Input registering: hsync_in, vsync_in and RGB are registered once. Edge detection uses the registered value against one more delayed copy. All position math uses the registered samples.
- Horizontal timing:
  - h_cnt (10 bit) loads 0 on the cycle a falling hsync edge is detected; otherwise it increments, saturating at 1023.
  - On each falling edge except the first after reset, the line length is checked: h_cnt+1 must equal H_TOTAL.
- Vertical timing:
  - v_cnt (10 bit) increments on each hsync falling edge.
  - v_cnt loads 0 on the hsync falling edge at which the registered vsync is first seen low (vsync edge qualified by hsync).
  - At that point frame length v_cnt+1 must equal V_TOTAL.
- Active region:
  - x = h_cnt - (H_SYNC+H_BP); y = v_cnt - (V_SYNC+V_BP).
  - Active when 0 <= x < H_DISPLAY and 0 <= y < V_DISPLAY.
  - Column k = x / BAR_WIDTH. Implement as a running column counter and intra-column counter reset at x=0; no divider.
- Bar decoding:
  - A pixel is lit when {r,g,b} == BAR_COLOUR. Any other colour, including white, is not lit.
  - For each active lit pixel: min_row[k] <= min(min_row[k], y).
  - At frame end (vsync-qualified hsync edge): if the FSM is LOCKED and the frame length is good, latch height[k] = V_DISPLAY - min_row[k] for all k and pulse frame_valid.
  - A column with no lit pixel gives height 0.
  - min_row[] is reinitialised to V_DISPLAY at every frame end, latched or not.
- FSM:
  - UNLOCKED: on the first frame end, go to ACQUIRE with good_frames = 0.
  - ACQUIRE: each frame whose lines and frame length are all good increments good_frames; at LOCK_FRAMES, go to LOCKED. Any violation returns to UNLOCKED.
  - LOCKED: any line or frame violation goes to UNLOCKED and deasserts locked on the next cycle. The in-progress frame is not latched.
- Errors:
  - error_count increments by 1 per violation (line or frame), saturating at 255.
  - Checks run in every state, except the partial line and frame following reset.
  - Simultaneous line and frame violation on the same edge counts as 2, saturating.
- Wrap-around: if h_cnt saturates at 1023 (hsync lost), raise one line violation when it reaches 1023, not repeatedly. If v_cnt reaches 1023, raise one frame violation.
- Read port: bar_height <= height[bar_sel] every cycle. A read on the cycle frame_valid pulses returns the previous set; the next cycle returns the new set.
- Reset mid-frame: everything returns to reset values immediately. The next partial line and frame are ignored for checking; lock needs 1 + LOCK_FRAMES frame ends.

Test Plan:
- Drive standard 800x525 timing, black RGB, for 3 frames from reset -> locked rises after the 3rd frame end; frame_valid pulses at that frame end; all heights 0; error_count 0.
- Render bars with top rows y = 480-h for h = {0,30,60,...,450} (bar k height 30k) plus white pixels at x = 40k -> after lock, reading bar_sel = 0..15 returns 30k exactly; white is ignored.
- Lock, then shorten one line to 799 clocks -> error_count +1; locked falls; no frame_valid for that frame; re-locks after LOCK_FRAMES further good frames.
- Lock, then send one frame of 524 lines -> frame violation; error_count +1; heights hold previous values.
- Hold hsync_in high for 2000 clocks -> exactly one line violation; locked = 0; then inject 300 violations -> error_count saturates at 255.
- Assert reset for 1 cycle in mid-frame while locked, then resume -> all outputs 0 next cycle; locked returns only after the 3rd frame end; first decoded heights are correct.
